// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: field widths and the per-stage control bundle.
package mips_pkg;

    localparam int REGW  = 5;
    localparam int ALUCW = 3;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             alusrc;
        logic             regdst;
        logic [ALUCW-1:0] alucontrol;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary register: hold freezes the contents, bubble loads BUBBLE_VAL.
module pipe_stage_reg #(
    parameter int           W          = 1,
    parameter logic [W-1:0] BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Hold outranks bubble so a frozen stage keeps its instruction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (!i_hold) begin
            if (i_bubble) r_q <= BUBBLE_VAL;
            else          r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_regs_emw.sv
// D/E, E/M and M/W pipeline registers with flush/stall handling, per-stage valid and a retire counter.
module pipe_regs_emw
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             validD,
    input  logic             regwriteD,
    input  logic             memtoregD,
    input  logic             memwriteD,
    input  logic             alusrcD,
    input  logic             regdstD,
    input  logic [ALUCW-1:0] alucontrolD,
    input  logic [REGW-1:0]  rsD,
    input  logic [REGW-1:0]  rtD,
    input  logic [REGW-1:0]  rdD,
    input  logic [WIDTH-1:0] srcaD,
    input  logic [WIDTH-1:0] srcbD,
    input  logic [WIDTH-1:0] signimmD,
    input  logic             flushE,
    input  logic             memstall,
    input  logic [WIDTH-1:0] aluoutE_in,
    input  logic [WIDTH-1:0] writedataE_in,
    input  logic [WIDTH-1:0] readdataM_in,
    output logic [REGW-1:0]  rsE,
    output logic [REGW-1:0]  rtE,
    output logic [REGW-1:0]  rdE,
    output logic             regwriteE,
    output logic             memtoregE,
    output logic             memwriteE,
    output logic             alusrcE,
    output logic             regdstE,
    output logic [ALUCW-1:0] alucontrolE,
    output logic [WIDTH-1:0] srcaE,
    output logic [WIDTH-1:0] srcbE,
    output logic [WIDTH-1:0] signimmE,
    output logic [REGW-1:0]  writeregE,
    output logic             regwriteM,
    output logic             memtoregM,
    output logic             memwriteM,
    output logic [REGW-1:0]  writeregM,
    output logic [WIDTH-1:0] aluoutM,
    output logic [WIDTH-1:0] writedataM,
    output logic             regwriteW,
    output logic             memtoregW,
    output logic [REGW-1:0]  writeregW,
    output logic [WIDTH-1:0] aluoutW,
    output logic [WIDTH-1:0] readdataW,
    output logic             validE,
    output logic             validM,
    output logic             validW,
    output logic [CNTW-1:0]  retired
);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  rd;
        logic [WIDTH-1:0] srca;
        logic [WIDTH-1:0] srcb;
        logic [WIDTH-1:0] simm;
        logic             valid;
    } de_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [REGW-1:0]  writereg;
        logic [WIDTH-1:0] aluout;
        logic [WIDTH-1:0] writedata;
        logic             valid;
    } em_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REGW-1:0]  writereg;
        logic [WIDTH-1:0] aluout;
        logic [WIDTH-1:0] readdata;
        logic             valid;
    } mw_t;

    localparam de_t DE_BUBBLE = '{ctrl: BUBBLE, default: '0};

    de_t w_de_d, w_de_q;
    em_t w_em_d, w_em_q;
    mw_t w_mw_d, w_mw_q;
    logic [CNTW-1:0] r_retired;

    // An invalid slot can never write the register file or memory.
    always_comb begin
        w_de_d                 = '0;
        w_de_d.ctrl.regwrite   = regwriteD & validD;
        w_de_d.ctrl.memtoreg   = memtoregD;
        w_de_d.ctrl.memwrite   = memwriteD & validD;
        w_de_d.ctrl.alusrc     = alusrcD;
        w_de_d.ctrl.regdst     = regdstD;
        w_de_d.ctrl.alucontrol = alucontrolD;
        w_de_d.rs              = rsD;
        w_de_d.rt              = rtD;
        w_de_d.rd              = rdD;
        w_de_d.srca            = srcaD;
        w_de_d.srcb            = srcbD;
        w_de_d.simm            = signimmD;
        w_de_d.valid           = validD;
    end

    pipe_stage_reg #(.W($bits(de_t)), .BUBBLE_VAL(DE_BUBBLE)) u_de (
        .clk(clk), .resetn(resetn), .i_hold(memstall), .i_bubble(flushE),
        .i_d(w_de_d), .o_q(w_de_q)
    );

    assign rsE         = w_de_q.rs;
    assign rtE         = w_de_q.rt;
    assign rdE         = w_de_q.rd;
    assign regwriteE   = w_de_q.ctrl.regwrite;
    assign memtoregE   = w_de_q.ctrl.memtoreg;
    assign memwriteE   = w_de_q.ctrl.memwrite;
    assign alusrcE     = w_de_q.ctrl.alusrc;
    assign regdstE     = w_de_q.ctrl.regdst;
    assign alucontrolE = w_de_q.ctrl.alucontrol;
    assign srcaE       = w_de_q.srca;
    assign srcbE       = w_de_q.srcb;
    assign signimmE    = w_de_q.simm;
    assign validE      = w_de_q.valid;
    assign writeregE   = w_de_q.ctrl.regdst ? w_de_q.rd : w_de_q.rt;

    always_comb begin
        w_em_d           = '0;
        w_em_d.regwrite  = regwriteE;
        w_em_d.memtoreg  = memtoregE;
        w_em_d.memwrite  = memwriteE;
        w_em_d.writereg  = writeregE;
        w_em_d.aluout    = aluoutE_in;
        w_em_d.writedata = writedataE_in;
        w_em_d.valid     = validE;
    end

    pipe_stage_reg #(.W($bits(em_t))) u_em (
        .clk(clk), .resetn(resetn), .i_hold(memstall), .i_bubble(1'b0),
        .i_d(w_em_d), .o_q(w_em_q)
    );

    assign regwriteM  = w_em_q.regwrite;
    assign memtoregM  = w_em_q.memtoreg;
    assign memwriteM  = w_em_q.memwrite;
    assign writeregM  = w_em_q.writereg;
    assign aluoutM    = w_em_q.aluout;
    assign writedataM = w_em_q.writedata;
    assign validM     = w_em_q.valid;

    always_comb begin
        w_mw_d          = '0;
        w_mw_d.regwrite = regwriteM;
        w_mw_d.memtoreg = memtoregM;
        w_mw_d.writereg = writeregM;
        w_mw_d.aluout   = aluoutM;
        w_mw_d.readdata = readdataM_in;
        w_mw_d.valid    = validM;
    end

    // While memory stalls, W drains: each stalled cycle becomes one bubble.
    pipe_stage_reg #(.W($bits(mw_t))) u_mw (
        .clk(clk), .resetn(resetn), .i_hold(1'b0), .i_bubble(memstall),
        .i_d(w_mw_d), .o_q(w_mw_q)
    );

    assign regwriteW = w_mw_q.regwrite;
    assign memtoregW = w_mw_q.memtoreg;
    assign writeregW = w_mw_q.writereg;
    assign aluoutW   = w_mw_q.aluout;
    assign readdataW = w_mw_q.readdata;
    assign validW    = w_mw_q.valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     r_retired <= '0;
        else if (validW) r_retired <= r_retired + CNTW'(1);
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_pipe_regs_emw.sv
// Self-checking bench: directed vector table, random traffic against a transaction model, wrap and reset cases.
module tb_pipe_regs_emw;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        validD, regwriteD, memtoregD, memwriteD, alusrcD, regdstD;
    logic [2:0]  alucontrolD;
    logic [4:0]  rsD, rtD, rdD;
    logic [31:0] srcaD, srcbD, signimmD;
    logic        flushE, memstall;
    logic [31:0] aluoutE_in, writedataE_in, readdataM_in;

    logic [4:0]  rsE, rtE, rdE, writeregE, writeregM, writeregW;
    logic        regwriteE, memtoregE, memwriteE, alusrcE, regdstE;
    logic [2:0]  alucontrolE;
    logic [31:0] srcaE, srcbE, signimmE, aluoutM, writedataM, aluoutW, readdataW;
    logic        regwriteM, memtoregM, memwriteM, regwriteW, memtoregW;
    logic        validE, validM, validW;
    logic [31:0] retired;

    logic [4:0]  s_rsE, s_rtE, s_rdE, s_writeregE, s_writeregM, s_writeregW;
    logic        s_regwriteE, s_memtoregE, s_memwriteE, s_alusrcE, s_regdstE;
    logic [2:0]  s_alucontrolE;
    logic [31:0] s_srcaE, s_srcbE, s_signimmE, s_aluoutM, s_writedataM, s_aluoutW, s_readdataW;
    logic        s_regwriteM, s_memtoregM, s_memwriteM, s_regwriteW, s_memtoregW;
    logic        s_validE, s_validM, s_validW;
    logic [3:0]  s_retired;

    always #5 clk = ~clk;

    pipe_regs_emw dut (
        .clk(clk), .resetn(resetn), .validD(validD), .regwriteD(regwriteD),
        .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD),
        .alucontrolD(alucontrolD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .srcaD(srcaD), .srcbD(srcbD), .signimmD(signimmD), .flushE(flushE), .memstall(memstall),
        .aluoutE_in(aluoutE_in), .writedataE_in(writedataE_in), .readdataM_in(readdataM_in),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .memwriteE(memwriteE), .alusrcE(alusrcE), .regdstE(regdstE), .alucontrolE(alucontrolE),
        .srcaE(srcaE), .srcbE(srcbE), .signimmE(signimmE), .writeregE(writeregE),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .memwriteM(memwriteM), .writeregM(writeregM),
        .aluoutM(aluoutM), .writedataM(writedataM), .regwriteW(regwriteW), .memtoregW(memtoregW),
        .writeregW(writeregW), .aluoutW(aluoutW), .readdataW(readdataW),
        .validE(validE), .validM(validM), .validW(validW), .retired(retired)
    );

    pipe_regs_emw #(.CNTW(4)) dut_small (
        .clk(clk), .resetn(resetn), .validD(validD), .regwriteD(regwriteD),
        .memtoregD(memtoregD), .memwriteD(memwriteD), .alusrcD(alusrcD), .regdstD(regdstD),
        .alucontrolD(alucontrolD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .srcaD(srcaD), .srcbD(srcbD), .signimmD(signimmD), .flushE(flushE), .memstall(memstall),
        .aluoutE_in(aluoutE_in), .writedataE_in(writedataE_in), .readdataM_in(readdataM_in),
        .rsE(s_rsE), .rtE(s_rtE), .rdE(s_rdE), .regwriteE(s_regwriteE), .memtoregE(s_memtoregE),
        .memwriteE(s_memwriteE), .alusrcE(s_alusrcE), .regdstE(s_regdstE), .alucontrolE(s_alucontrolE),
        .srcaE(s_srcaE), .srcbE(s_srcbE), .signimmE(s_signimmE), .writeregE(s_writeregE),
        .regwriteM(s_regwriteM), .memtoregM(s_memtoregM), .memwriteM(s_memwriteM), .writeregM(s_writeregM),
        .aluoutM(s_aluoutM), .writedataM(s_writedataM), .regwriteW(s_regwriteW), .memtoregW(s_memtoregW),
        .writeregW(s_writeregW), .aluoutW(s_aluoutW), .readdataW(s_readdataW),
        .validE(s_validE), .validM(s_validM), .validW(s_validW), .retired(s_retired)
    );

    // One record per instruction slot; each stage of the model holds one.
    typedef struct packed {
        logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst;
        logic [2:0]  aluc;
        logic [4:0]  rs, rt, rd, writereg;
        logic [31:0] srca, srcb, simm, aluout, writedata, readdata;
    } ins_t;

    ins_t        mE, mM, mW;
    int unsigned exp_ret;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic       valid, rw, mtr, mw, regdst;
        logic [4:0] rt, rd;
        logic       flush, stall;
        logic [4:0] e_wrE, e_wrM, e_wrW;
        logic       e_vW, e_rwE, e_mwE;
        int         e_ret;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mE = '0; mM = '0; mW = '0; exp_ret = 0;
    endtask

    task automatic model_edge();
        ins_t nE, nM, nW;
        if (mW.valid) exp_ret++;
        if (memstall) begin
            nE = mE; nM = mM; nW = '0;
        end else begin
            nW = mM;
            nW.readdata = readdataM_in;
            nM = '0;
            nM.valid = mE.valid; nM.regwrite = mE.regwrite; nM.memtoreg = mE.memtoreg;
            nM.memwrite = mE.memwrite; nM.writereg = mE.writereg;
            nM.aluout = aluoutE_in; nM.writedata = writedataE_in;
            nE = '0;
            if (!flushE) begin
                nE.valid = validD; nE.regwrite = regwriteD && validD; nE.memtoreg = memtoregD;
                nE.memwrite = memwriteD && validD; nE.alusrc = alusrcD; nE.regdst = regdstD;
                nE.aluc = alucontrolD; nE.rs = rsD; nE.rt = rtD; nE.rd = rdD;
                nE.writereg = regdstD ? rdD : rtD;
                nE.srca = srcaD; nE.srcb = srcbD; nE.simm = signimmD;
            end
        end
        mE = nE; mM = nM; mW = nW;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ctlE"},
            128'({regwriteE, memtoregE, memwriteE, alusrcE, regdstE, alucontrolE, rsE, rtE, rdE, validE}),
            128'({mE.regwrite, mE.memtoreg, mE.memwrite, mE.alusrc, mE.regdst, mE.aluc, mE.rs, mE.rt, mE.rd, mE.valid}));
        chk({tag, ".datE"}, 128'({srcaE, srcbE, signimmE}), 128'({mE.srca, mE.srcb, mE.simm}));
        chk({tag, ".wrE"}, 128'(writeregE), 128'(mE.writereg));
        chk({tag, ".ctlM"}, 128'({regwriteM, memtoregM, memwriteM, writeregM, validM}),
            128'({mM.regwrite, mM.memtoreg, mM.memwrite, mM.writereg, mM.valid}));
        chk({tag, ".datM"}, 128'({aluoutM, writedataM}), 128'({mM.aluout, mM.writedata}));
        chk({tag, ".ctlW"}, 128'({regwriteW, memtoregW, writeregW, validW}),
            128'({mW.regwrite, mW.memtoreg, mW.writereg, mW.valid}));
        chk({tag, ".datW"}, 128'({aluoutW, readdataW}), 128'({mW.aluout, mW.readdata}));
        chk({tag, ".retired"}, 128'(retired), 128'(exp_ret));
        chk({tag, ".retired4"}, 128'(s_retired), 128'(exp_ret % 16));
        chk({tag, ".small_W"}, 128'({s_writeregW, s_validW, s_aluoutW}), 128'({mW.writereg, mW.valid, mW.aluout}));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic zero_inputs();
        validD = 0; regwriteD = 0; memtoregD = 0; memwriteD = 0; alusrcD = 0; regdstD = 0;
        alucontrolD = 0; rsD = 0; rtD = 0; rdD = 0; srcaD = 0; srcbD = 0; signimmD = 0;
        flushE = 0; memstall = 0; aluoutE_in = 0; writedataE_in = 0; readdataM_in = 0;
    endtask

    task automatic rand_inputs(input int stall_pct, input int flush_pct);
        logic [31:0] r;
        r = $urandom;
        rsD = r[4:0]; rtD = r[9:5]; rdD = r[14:10]; alucontrolD = r[17:15];
        regwriteD = r[18]; memtoregD = r[19]; memwriteD = r[20]; alusrcD = r[21]; regdstD = r[22];
        validD = (r[26:23] != 4'd0);
        srcaD = $urandom; srcbD = $urandom; signimmD = $urandom;
        aluoutE_in = $urandom; writedataE_in = $urandom; readdataM_in = $urandom;
        memstall = ($urandom_range(0, 99) < stall_pct);
        flushE = ($urandom_range(0, 99) < flush_pct);
    endtask

    // Reset asserted away from any clock edge; outputs must clear before the next edge.
    task automatic reset_dut(input string tag);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 model_clear();
        check_all({tag, ".async"});
        @(negedge clk);
        zero_inputs();
        resetn = 1'b1;
        check_all({tag, ".held"});
    endtask

    initial begin
        zero_inputs();
        model_clear();

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 5'd5, 1'b0, 1'b0, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd1, 1'b0, 1'b0, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd8, 1'b1, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd8, 1'b0, 1'b1, 5'd4, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd8, 1'b0, 1'b0, 5'd8, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0, 1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd4, 1'b1, 1'b0, 1'b0, 1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 2};

        reset_dut("init");

        for (int i = 0; i < 10; i++) begin
            validD = tbl[i].valid; regwriteD = tbl[i].rw; memtoregD = tbl[i].mtr;
            memwriteD = tbl[i].mw; regdstD = tbl[i].regdst; rtD = tbl[i].rt; rdD = tbl[i].rd;
            flushE = tbl[i].flush; memstall = tbl[i].stall;
            rsD = 5'(i); srcaD = 32'h11; srcbD = 32'(i); signimmD = 32'(3 * i);
            aluoutE_in = $urandom; writedataE_in = $urandom; readdataM_in = $urandom;
            step("vec");
            chk($sformatf("vec%0d.wrE", i), 128'(writeregE), 128'(tbl[i].e_wrE));
            chk($sformatf("vec%0d.wrM", i), 128'(writeregM), 128'(tbl[i].e_wrM));
            chk($sformatf("vec%0d.wrW", i), 128'(writeregW), 128'(tbl[i].e_wrW));
            chk($sformatf("vec%0d.vW", i), 128'(validW), 128'(tbl[i].e_vW));
            chk($sformatf("vec%0d.rwE", i), 128'(regwriteE), 128'(tbl[i].e_rwE));
            chk($sformatf("vec%0d.mwE", i), 128'(memwriteE), 128'(tbl[i].e_mwE));
            chk($sformatf("vec%0d.ret", i), 128'(retired), 128'(tbl[i].e_ret));
        end

        for (int i = 0; i < 3000; i++) begin
            rand_inputs(20, 15);
            step("rand");
        end

        // Sixteen retirements take the 4-bit counter exactly around to zero.
        reset_dut("wrap");
        for (int i = 0; i < 20; i++) begin
            rand_inputs(0, 0);
            validD = (i < 16);
            step("wrap");
        end
        chk("wrap.small", 128'(s_retired), 128'(0));
        chk("wrap.main", 128'(retired), 128'(16));

        for (int i = 0; i < 12; i++) begin
            rand_inputs(10, 10);
            validD = 1'b1;
            step("pre_rst");
        end
        reset_dut("midrst");
        for (int i = 0; i < 4; i++) step("post_rst");
        chk("post_rst.validW", 128'(validW), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
